pc_sequencer: RTL

//  Owns the architectural PC and sequences instruction fetch for the MIPS core, one instruction at a time.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/npc_calc.sv | 35 +++
 rtl/pc_sequencer.sv | 118 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch front end.
// Holds the sequencer state encoding, the control-flow op codes and the boot address.
package mips_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  localparam logic [2:0] NPC_SEQ = 3'b000;
  localparam logic [2:0] NPC_BR  = 3'b001;
  localparam logic [2:0] NPC_J   = 3'b010;
  localparam logic [2:0] NPC_JR  = 3'b011;

  typedef enum logic [2:0] {
    ST_BOOT    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_RESOLVE = 3'd3,
    ST_ERR     = 3'd4
  } seq_state_t;

  // Instruction addresses must be word aligned; only the two low bits matter.
  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage

// File: rtl/npc_calc.sv
// Combinational next-PC generator.
// Produces the link value (pc + 4) and the next fetch address for the resolved op.
module npc_calc
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic [2:0]  op,
  input  logic [31:0] pc,
  input  logic [25:0] imm26,
  input  logic [31:0] reg32,
  output logic [31:0] pc_plus4,
  output logic [31:0] npc
);

  logic [31:0] br_offset;
  logic [31:0] jump_target;

  assign pc_plus4    = pc + 32'd4;
  assign br_offset   = {{14{imm26[15]}}, imm26[15:0], 2'b00};
  assign jump_target = {pc[31:28], imm26, 2'b00};

  // Select the next PC; any op code outside the four defined ones restarts at the boot address.
  always_comb begin
    npc = RESET_PC;
    case (op)
      NPC_SEQ: npc = pc_plus4;
      NPC_BR:  npc = pc_plus4 + br_offset;
      NPC_J:   npc = jump_target;
      NPC_JR:  npc = reg32;
      default: npc = RESET_PC;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner and single-issue fetch sequencer.
// Fetches one word from imem, offers it to decode, then waits for decode to resolve control flow.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             if_valid,
  input  logic             if_ready,
  output logic [31:0]      if_instr,
  output logic [31:0]      if_pc,
  output logic [31:0]      if_pc_plus4,
  input  logic             rs_valid,
  output logic             rs_ready,
  input  logic [2:0]       rs_op,
  input  logic [25:0]      rs_imm26,
  input  logic [31:0]      rs_reg32,
  output logic             fetch_err,
  output logic [CNT_W-1:0] instr_cnt
);

  seq_state_t  state;
  seq_state_t  state_next;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        fetch_done;
  logic        resolve_done;

  // The next PC is always computed from the held instruction's PC, never the live fetch address.
  npc_calc #(
    .RESET_PC (RESET_PC)
  ) u_npc_calc (
    .op       (rs_op),
    .pc       (if_pc),
    .imm26    (rs_imm26),
    .reg32    (rs_reg32),
    .pc_plus4 (if_pc_plus4),
    .npc      (npc)
  );

  assign imem_addr    = pc;
  assign fetch_done   = (state == ST_FETCH) && imem_ack;
  assign resolve_done = (state == ST_RESOLVE) && rs_valid;

  // State register; reset forces BOOT so a late ack from an aborted fetch is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_BOOT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and state-decoded handshake outputs; ERR drives nothing and never leaves.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    if_valid   = 1'b0;
    rs_ready   = 1'b0;
    case (state)
      ST_BOOT: begin
        state_next = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        if_valid = 1'b1;
        if (if_ready) state_next = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        rs_ready = 1'b1;
        if (rs_valid) begin
          state_next = is_word_aligned(npc[1:0]) ? ST_FETCH : ST_ERR;
        end
      end
      ST_ERR: begin
        state_next = ST_ERR;
      end
      default: begin
        state_next = ST_BOOT;
      end
    endcase
  end

  // Instruction register: capture the word and its address on the fetch acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_instr <= 32'd0;
      if_pc    <= RESET_PC;
    end else if (fetch_done) begin
      if_instr <= imem_rdata;
      if_pc    <= pc;
    end
  end

  // Architectural PC, retire counter and sticky alignment error all update on resolution.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      instr_cnt <= '0;
      fetch_err <= 1'b0;
    end else if (resolve_done) begin
      pc        <= npc;
      instr_cnt <= instr_cnt + CNT_W'(1);
      if (!is_word_aligned(npc[1:0])) fetch_err <= 1'b1;
    end
  end

endmodule
